// File: rtl/spi_link_pkg.sv
// Shared definitions for the SPI link: receiver state encoding and the
// word width common to the master and the receiver.
package spi_link_pkg;

  localparam int WORD_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } rx_state_t;

endpackage

// File: rtl/spi_frame_receiver_if.sv
// Bundle of serial pins, the valid/ready word output and status flags of
// the SPI frame receiver. "master" is the link/consumer side, "slave" the receiver.
interface spi_frame_receiver_if
  import spi_link_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEFAULT
);

  logic              sclk;
  logic              sync;
  logic              mosi;
  logic [WORD_W-1:0] word_data;
  logic              word_valid;
  logic              word_ready;
  logic              busy;
  logic              overflow;
  logic              frame_err;

  modport master (
    output sclk, sync, mosi, word_ready,
    input  word_data, word_valid, busy, overflow, frame_err
  );

  modport slave (
    input  sclk, sync, mosi, word_ready,
    output word_data, word_valid, busy, overflow, frame_err
  );

endinterface

// File: rtl/spi_in_sync.sv
// Single-bit multi-flop synchronizer for an asynchronous serial pin,
// cleared by the synchronous reset.
module spi_in_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] ff;

  if (SYNC_STAGES < 2) begin : g_bad_stages
    $error("spi_in_sync: SYNC_STAGES must be at least 2");
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ff <= '0;
    end else begin
      ff <= {ff[SYNC_STAGES-2:0], d};
    end
  end

  assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/spi_frame_receiver.sv
// Oversampling SPI frame receiver: reassembles sync-delimited frames MSB first
// into words on a one-entry valid/ready output. Optional SHIFT timeout: SPI_RX_TIMEOUT_EN.
module spi_frame_receiver
  import spi_link_pkg::*;
#(
  parameter int WORD_W         = WORD_W_DEFAULT,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  spi_frame_receiver_if.slave  bus
);

  localparam int CNT_W = $clog2(WORD_W + 1);

  logic              s_sclk;
  logic              s_sync;
  logic              s_mosi;
  logic              sclk_q;
  logic              sync_q;
  logic              fall;
  logic              sync_rise;
  rx_state_t         state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [WORD_W-1:0] shreg;
  logic [WORD_W-1:0] word_data;
  logic              word_valid;
  logic              overflow;
  logic              frame_err;

  if (WORD_W < 2) begin : g_bad_width
    $error("spi_frame_receiver: WORD_W must be at least 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("spi_frame_receiver: TIMEOUT_CYCLES must be positive");
  end

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk (clk), .rst (rst), .d (bus.sclk), .q (s_sclk)
  );
  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sync (
    .clk (clk), .rst (rst), .d (bus.sync), .q (s_sync)
  );
  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk (clk), .rst (rst), .d (bus.mosi), .q (s_mosi)
  );

  assign fall      = sclk_q & ~s_sclk;
  assign sync_rise = ~sync_q & s_sync;

`ifdef SPI_RX_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_hit;
  assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`endif

  // Edge detection, frame FSM and output register share one process so every
  // flag is registered; a transfer clears valid unless DONE reloads it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      word_data  <= '0;
      word_valid <= 1'b0;
      overflow   <= 1'b0;
      frame_err  <= 1'b0;
      sclk_q     <= 1'b0;
      sync_q     <= 1'b0;
`ifdef SPI_RX_TIMEOUT_EN
      tmo_cnt    <= '0;
`endif
    end else begin
      sclk_q    <= s_sclk;
      sync_q    <= s_sync;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
`ifdef SPI_RX_TIMEOUT_EN
      tmo_cnt   <= '0;
`endif
      if (word_valid && bus.word_ready) begin
        word_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          bit_cnt <= '0;
          if (sync_rise) begin
            state <= SHIFT;
          end
        end

        SHIFT: begin
          if (sync_rise) begin
            if (bit_cnt != '0) begin
              frame_err <= 1'b1;
            end
            bit_cnt <= '0;
          end else if (fall) begin
            // A falling edge while sync is still high belongs to the overlap and is skipped.
            if (!s_sync) begin
              shreg   <= {shreg[WORD_W-2:0], s_mosi};
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == CNT_W'(WORD_W - 1)) begin
                state <= DONE;
              end
            end
          end
`ifdef SPI_RX_TIMEOUT_EN
          else if (tmo_hit) begin
            if (bit_cnt != '0) begin
              frame_err <= 1'b1;
            end
            bit_cnt <= '0;
            state   <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end

        DONE: begin
          if (!word_valid || bus.word_ready) begin
            word_data  <= shreg;
            word_valid <= 1'b1;
          end else begin
            overflow <= 1'b1;
          end
          bit_cnt <= '0;
          state   <= IDLE;
        end

        default: begin
          bit_cnt <= '0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.word_data  = word_data;
  assign bus.word_valid = word_valid;
  assign bus.busy       = (state != IDLE);
  assign bus.overflow   = overflow;
  assign bus.frame_err  = frame_err;

endmodule

// File: doc/spi_frame_receiver.md
# spi_frame_receiver

Serial-to-parallel receiver for the three-wire frame format (`sync`, `sclk`, `mosi`) produced by our SPI master. It oversamples the serial pins in the `clk` domain and reassembles each frame into a `WORD_W`-bit word, MSB first. Each completed word is presented on a one-entry valid/ready output. It sits at the far end of the link as a loopback/monitor target and as the front end of any FPGA-side DAC model.

## Interface
- `WORD_W`, default 16: bits per frame.
- `SYNC_STAGES`, default 2: flip-flop stages in each input synchronizer; minimum 2.
- `TIMEOUT_CYCLES`, default 4096: `clk` cycles without an `sclk` falling edge before an open frame is aborted.
- `clk` in, 1 bit: single clock. Must run at least 4× the `sclk` rate; `sclk` high and low phases are each at least 1 `clk` period.
- `rst` in, 1 bit: synchronous, active-high reset.
- `sclk` in, 1 bit: serial clock, asynchronous to `clk`.
- `sync` in, 1 bit: frame marker, active high, asynchronous.
- `mosi` in, 1 bit: serial data, asynchronous. Changes on `sclk` rising edge.
- `word_data` out, `WORD_W` bits: received word.
- `word_valid` out, 1 bit: `word_data` holds an unconsumed word.
- `word_ready` in, 1 bit: consumer accepts the word.
- `busy` out, 1 bit: a frame is in progress.
- `overflow` out, 1 bit: one-cycle pulse when a completed word is dropped.
- `frame_err` out, 1 bit: one-cycle pulse when a frame is aborted.

## Operation
- `sclk`, `sync` and `mosi` each pass through a `SYNC_STAGES` synchronizer. All decisions use the synchronized values `s_sclk`, `s_sync` and `s_mosi`.
- `fall` = previous `s_sclk` AND NOT current `s_sclk`. `sync_rise` is defined the same way on `s_sync`.
- State IDLE:
  - `bit_cnt` = 0.
  - On `sync_rise`, go to SHIFT.
- State SHIFT:
  - On `fall` with `s_sync` low: `shreg` = {`shreg`[WORD_W-2:0], `s_mosi`} and `bit_cnt` increments.
  - A `fall` with `s_sync` high is ignored (sync overlap).
  - On the `WORD_W`-th bit, go to DONE.
- State DONE (one cycle):
  - If the output is free, load `word_data` and set `word_valid`.
  - If the output is occupied and `word_ready` is low, drop the new word and pulse `overflow`.
  - Return to IDLE.
- Output handshake:
  - A transfer occurs when `word_valid` and `word_ready` are both high on a clock edge. `word_valid` clears on that edge unless DONE loads a new word in the same cycle.
  - DONE and a transfer in the same cycle: the new word loads and `word_valid` stays high. No overflow.
  - `word_data` is stable while `word_valid` is high.
- `busy` = (state != IDLE).
- `sync_rise` in SHIFT with `bit_cnt` > 0:
  - Pulse `frame_err`, discard the partial word, restart SHIFT with `bit_cnt` = 0.
  - With `bit_cnt` = 0, simply remain in SHIFT.
- `bit_cnt` width is $clog2(WORD_W+1). It never wraps.

## Timing
- Reset values: `word_data` = 0, `word_valid` = 0, `busy` = 0, `overflow` = 0, `frame_err` = 0; state = IDLE; synchronizers cleared.
- `rst` mid-frame or mid-handshake discards everything on the next edge. No pulses are generated.
- Latency from the last `sclk` pin falling edge to `word_valid` = `SYNC_STAGES` + 2 `clk` cycles: synchronizer stages, then the edge-detect register, then DONE.
- `overflow` and `frame_err` are high for exactly one cycle per event.
- Back-to-back frames: a new `sync_rise` may arrive in the cycle after DONE. It is not lost, because DONE always lasts exactly one cycle.

## Configuration
- `SPI_RX_TIMEOUT_EN` defined:
  - In SHIFT, a counter counts `clk` cycles since the last `fall` or entry into SHIFT.
  - When it reaches `TIMEOUT_CYCLES` with `bit_cnt` > 0: pulse `frame_err` and go to IDLE.
  - With `bit_cnt` = 0: go to IDLE silently.
- `SPI_RX_TIMEOUT_EN` undefined:
  - No counter. SHIFT waits indefinitely.
  - `TIMEOUT_CYCLES` is unused.

## Structure
- Package `spi_link_pkg`:
  - `rx_state_t` enum (IDLE, SHIFT, DONE).
  - Default `WORD_W` constant 16, shared with the master.
- Sub-module `spi_in_sync`: parameterized `SYNC_STAGES`, 1-bit. Instantiated three times.

## Test plan
- Send `sync` pulse, then 16 bits 0xA5C3. `word_valid` rises `SYNC_STAGES`+2 cycles after the last `sclk` fall, with `word_data` = 0xA5C3. `word_ready` = 1 clears it on the next edge.
- Send two frames, 0x1234 then 0xBEEF, with `word_ready` held low. `word_data` stays 0x1234 and `overflow` pulses once. Raise `word_ready`: `word_valid` drops.
- Send 7 bits, then a new `sync_rise`, then 16 bits 0x00FF. `frame_err` pulses once and `word_data` = 0x00FF.
- Send a 0xFFFF frame whose DONE coincides with a handshake on a prior 0x0001 word. The 0x0001 word transfers, `word_valid` stays high, `word_data` = 0xFFFF, no `overflow`.
- Assert `rst` after 9 bits. `busy` = 0 next cycle and no pulses. A following frame 0x8001 is received intact.
- With `SPI_RX_TIMEOUT_EN` defined and `TIMEOUT_CYCLES` = 64: send 5 bits, then stop `sclk`. After 64 cycles `frame_err` pulses and `busy` = 0. Without the macro, `busy` stays 1.
